// File: rtl/fft_memctrl.sv
// fft_memctrl: address/control sequencer for an in-place radix-2 FFT using
// two ping-pong RAMs. Loads samples bit-reversed into RAM0, runs L stages
// (one butterfly per cycle), then streams results from the final bank.
module fft_memctrl #(
    parameter int LOG2N_MAX = 9,
    parameter int BF_LAT    = 2,
    localparam int AW = LOG2N_MAX,
    localparam int TW = LOG2N_MAX - 1,
    localparam int CW = $clog2(LOG2N_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] cfg_log2n,
    input  logic          start,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    output logic          bf_valid,
    output logic [AW-1:0] r0_add_a,
    output logic [AW-1:0] r0_add_b,
    output logic [AW-1:0] r1_add_a,
    output logic [AW-1:0] r1_add_b,
    output logic          mem_write0,
    output logic          mem_write1,
    output logic [TW-1:0] add_tw,
    output logic [TW-1:0] add_tw_dly,
    output logic          read_sel,
    output logic          result_bank,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic          out_valid,
    output logic          busy,
    output logic          fft_done
);

    typedef enum logic [2:0] {IDLE, COMPUTE, GAP, FLUSH, OUT, DONE} state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] l_r, s_r;
    logic [TW-1:0] b_r;
    logic [2:0]    cnt_r;
    logic [AW-1:0] out_idx_r;

    // write-back delay line: one entry per butterfly in flight
    logic          dly_v_r    [BF_LAT];
    logic          dly_bank_r [BF_LAT];
    logic [AW-1:0] dly_a_r    [BF_LAT];
    logic [AW-1:0] dly_p_r    [BF_LAT];
    logic [TW-1:0] dly_tw_r   [BF_LAT];

    logic [AW:0]   n_s;
    logic [AW-1:0] n_m1_s, bz_s, mask_s, a_s, pair_s, load_rev_s;
    logic [TW-1:0] last_b_s, tw_s;
    logic [CW-1:0] tw_sh_s, cfg_l_s;

    // Clamp a requested size to the supported 2..LOG2N_MAX range
    function automatic logic [CW-1:0] clamp_l(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v < CW'(2)) begin
            r = CW'(2);
        end else if (v > CW'(LOG2N_MAX)) begin
            r = CW'(LOG2N_MAX);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Reverse the low l bits of v; bits at and above l are zero
    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v, input logic [CW-1:0] l);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            if (i < int'(l)) begin
                r[i] = v[int'(l) - 1 - i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Butterfly address, twiddle and size arithmetic for the current stage
    always_comb begin
        cfg_l_s    = clamp_l(cfg_log2n);
        load_rev_s = bit_rev(load_addr, cfg_l_s);
        n_s        = (AW+1)'(1) << l_r;
        n_m1_s     = AW'(n_s - (AW+1)'(1));
        last_b_s   = TW'((n_s >> 1) - (AW+1)'(1));
        bz_s       = AW'(b_r);
        mask_s     = (AW'(1) << s_r) - AW'(1);
        a_s        = ((bz_s >> s_r) << (s_r + CW'(1))) | (bz_s & mask_s);
        pair_s     = a_s | (AW'(1) << s_r);
        tw_sh_s    = CW'(LOG2N_MAX - 1) - s_r;
        tw_s       = TW'((bz_s & mask_s) << tw_sh_s);
    end

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = COMPUTE;
                else       state_s = IDLE;
            end
            COMPUTE: begin
                if (b_r == last_b_s) begin
                    if (s_r == l_r - CW'(1)) state_s = FLUSH;
                    else                     state_s = GAP;
                end else begin
                    state_s = COMPUTE;
                end
            end
            GAP: begin
                if (cnt_r == 3'(BF_LAT - 1)) state_s = COMPUTE;
                else                         state_s = GAP;
            end
            FLUSH: begin
                if (cnt_r == 3'(BF_LAT - 1)) state_s = OUT;
                else                         state_s = FLUSH;
            end
            OUT: begin
                if (out_ready && out_idx_r == n_m1_s) state_s = DONE;
                else                                  state_s = OUT;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode: reads/loads from the active state, writes from the delay line
    always_comb begin
        bf_valid    = 1'b0;
        r0_add_a    = '0;
        r0_add_b    = '0;
        r1_add_a    = '0;
        r1_add_b    = '0;
        mem_write0  = 1'b0;
        mem_write1  = 1'b0;
        add_tw      = '0;
        out_valid   = 1'b0;
        fft_done    = 1'b0;
        busy        = (state_r != IDLE);
        read_sel    = s_r[0];
        result_bank = busy ? l_r[0] : 1'b0;
        out_idx     = out_idx_r;
        add_tw_dly  = dly_tw_r[BF_LAT-1];
        case (state_r)
            IDLE: begin
                if (load_valid) begin
                    mem_write0 = 1'b1;
                    r0_add_a   = load_rev_s;
                    r0_add_b   = load_rev_s;
                end else begin
                    mem_write0 = 1'b0;
                end
            end
            COMPUTE: begin
                bf_valid = 1'b1;
                add_tw   = tw_s;
                if (s_r[0]) begin
                    r1_add_a = a_s;
                    r1_add_b = pair_s;
                end else begin
                    r0_add_a = a_s;
                    r0_add_b = pair_s;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (l_r[0]) r1_add_a = out_idx_r;
                else        r0_add_a = out_idx_r;
            end
            DONE:    fft_done = 1'b1;
            default: fft_done = 1'b0;
        endcase
        // destination bank is always the one not being read, so no port clash
        if (dly_v_r[BF_LAT-1]) begin
            if (dly_bank_r[BF_LAT-1]) begin
                mem_write1 = 1'b1;
                r1_add_a   = dly_a_r[BF_LAT-1];
                r1_add_b   = dly_p_r[BF_LAT-1];
            end else begin
                mem_write0 = 1'b1;
                r0_add_a   = dly_a_r[BF_LAT-1];
                r0_add_b   = dly_p_r[BF_LAT-1];
            end
        end else begin
            add_tw_dly = dly_tw_r[BF_LAT-1];
        end
    end

    // State, counters and write-back delay line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            l_r       <= CW'(LOG2N_MAX);
            s_r       <= '0;
            b_r       <= '0;
            cnt_r     <= '0;
            out_idx_r <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                dly_v_r[i]    <= 1'b0;
                dly_bank_r[i] <= 1'b0;
                dly_a_r[i]    <= '0;
                dly_p_r[i]    <= '0;
                dly_tw_r[i]   <= '0;
            end
        end else begin
            state_r       <= state_s;
            dly_v_r[0]    <= bf_valid;
            dly_bank_r[0] <= bf_valid & ~s_r[0];
            dly_a_r[0]    <= bf_valid ? a_s : '0;
            dly_p_r[0]    <= bf_valid ? pair_s : '0;
            dly_tw_r[0]   <= add_tw;
            for (int i = 1; i < BF_LAT; i++) begin
                dly_v_r[i]    <= dly_v_r[i-1];
                dly_bank_r[i] <= dly_bank_r[i-1];
                dly_a_r[i]    <= dly_a_r[i-1];
                dly_p_r[i]    <= dly_p_r[i-1];
                dly_tw_r[i]   <= dly_tw_r[i-1];
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        l_r   <= cfg_l_s;
                        s_r   <= '0;
                        b_r   <= '0;
                        cnt_r <= '0;
                    end
                end
                COMPUTE: begin
                    cnt_r <= '0;
                    if (b_r == last_b_s) b_r <= '0;
                    else                 b_r <= b_r + TW'(1);
                end
                GAP: begin
                    if (cnt_r == 3'(BF_LAT - 1)) begin
                        cnt_r <= '0;
                        s_r   <= s_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                FLUSH: begin
                    if (cnt_r == 3'(BF_LAT - 1)) cnt_r <= '0;
                    else                         cnt_r <= cnt_r + 3'd1;
                end
                OUT: begin
                    if (out_ready) out_idx_r <= out_idx_r + AW'(1);
                end
                DONE: begin
                    out_idx_r <= '0;
                    s_r       <= '0;
                    b_r       <= '0;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_memctrl.sv
// Self-checking bench for fft_memctrl: a loop-based FFT schedule model fills
// scoreboard queues of expected reads/writes/results, popped as the DUT acts.
module tb_fft_memctrl;
    localparam int LOG2N_MAX = 9;
    localparam int BF_LAT    = 2;
    localparam int AW = LOG2N_MAX;
    localparam int TW = LOG2N_MAX - 1;
    localparam int CW = $clog2(LOG2N_MAX + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] cfg_log2n = '0;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic          bf_valid;
    logic [AW-1:0] r0_add_a, r0_add_b, r1_add_a, r1_add_b;
    logic          mem_write0, mem_write1;
    logic [TW-1:0] add_tw, add_tw_dly;
    logic          read_sel, result_bank;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_idx;
    logic          out_valid, busy, fft_done;

    fft_memctrl #(.LOG2N_MAX(LOG2N_MAX), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .reset(reset), .cfg_log2n(cfg_log2n), .start(start),
        .load_valid(load_valid), .load_addr(load_addr), .bf_valid(bf_valid),
        .r0_add_a(r0_add_a), .r0_add_b(r0_add_b), .r1_add_a(r1_add_a), .r1_add_b(r1_add_b),
        .mem_write0(mem_write0), .mem_write1(mem_write1), .add_tw(add_tw),
        .add_tw_dly(add_tw_dly), .read_sel(read_sel), .result_bank(result_bank),
        .out_ready(out_ready), .out_idx(out_idx), .out_valid(out_valid),
        .busy(busy), .fft_done(fft_done)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int p; int tw; int sel;} bf_t;
    bf_t rd_q[$];
    bf_t wr_q[$];
    int  wt_q[$];
    int  idx_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected butterfly schedule: stage, group, offset-within-group loops
    task automatic build_model(input int l);
        bf_t e;
        rd_q.delete(); wr_q.delete(); wt_q.delete(); idx_q.delete();
        for (int s = 0; s < l; s++)
            for (int g = 0; g < (1 << l); g += (1 << (s + 1)))
                for (int j = 0; j < (1 << s); j++) begin
                    e.a = g + j; e.p = g + j + (1 << s);
                    e.tw = j << (LOG2N_MAX - 1 - s); e.sel = s & 1;
                    rd_q.push_back(e); wr_q.push_back(e);
                end
        for (int i = 0; i < (1 << l); i++) idx_q.push_back(i);
    endtask

    task automatic run_fft(input int cfg, input int l, input bit toggle, input bit inject);
        bf_t e;
        int comp = 0, accepted = 0, done_pulses = 0, ra, rb, t0, exp_idx;
        bit finished = 0;
        build_model(l);
        @(negedge clk); cfg_log2n = CW'(cfg); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_start", busy, 1);
        check("result_bank", result_bank, l & 1);
        for (int k = 0; k < 6000 && !finished; k++) begin
            if (fft_done) begin
                done_pulses++;
                check("done_after_last", accepted, 1 << l);
                load_valid = 1'b0; out_ready = 1'b0;
                finished = 1;
            end else if (out_valid) begin
                ra = result_bank ? r1_add_a : r0_add_a;
                check("out_port", ra, out_idx);
                check("out_nowrite", {mem_write0, mem_write1}, 0);
                out_ready = toggle ? k[0] : 1'b1;
                if (out_ready) begin
                    exp_idx = (idx_q.size() > 0) ? idx_q.pop_front() : -1;
                    check("out_idx", out_idx, exp_idx);
                    accepted++;
                end
                if (inject) begin load_valid = 1'b1; load_addr = AW'(k); end
            end else if (busy) begin
                if (bf_valid) begin
                    if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                    else begin
                        e = rd_q.pop_front();
                        ra = read_sel ? r1_add_a : r0_add_a;
                        rb = read_sel ? r1_add_b : r0_add_b;
                        check("read_sel", read_sel, e.sel);
                        check("rd_a", ra, e.a);
                        check("rd_b", rb, e.p);
                        check("add_tw", add_tw, e.tw);
                        wt_q.push_back(comp);
                    end
                end
                if (mem_write0 || mem_write1) begin
                    if (wr_q.size() == 0 || wt_q.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        e = wr_q.pop_front();
                        t0 = wt_q.pop_front();
                        ra = mem_write1 ? r1_add_a : r0_add_a;
                        rb = mem_write1 ? r1_add_b : r0_add_b;
                        check("wr_one_bank", mem_write0 ^ mem_write1, 1);
                        check("wr_bank", mem_write1, (e.sel == 0) ? 1 : 0);
                        check("wr_a", ra, e.a);
                        check("wr_b", rb, e.p);
                        check("add_tw_dly", add_tw_dly, e.tw);
                        check("wr_latency", comp - t0, BF_LAT);
                    end
                end
                if (inject) begin
                    start      = (comp == 5);
                    load_valid = (comp == 5);
                    load_addr  = '0;
                end
                comp++;
            end else begin
                check("unexpected_idle", busy, 1);
                finished = 1;
            end
            if (!finished) @(negedge clk);
        end
        check("run_finished", finished, 1);
        check("compute_cycles", comp, l * ((1 << l) / 2 + BF_LAT));
        check("rd_q_empty", rd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("results", accepted, 1 << l);
        check("done_pulses", done_pulses, 1);
        @(negedge clk);
        check("done_one_cycle", fft_done, 0);
        check("idle_after", busy, 0);
    endtask

    task automatic load_check(input int cfg, input int addr, input int exp);
        @(negedge clk); cfg_log2n = CW'(cfg); load_valid = 1'b1; load_addr = AW'(addr);
        #1;
        check("load_we0", mem_write0, 1);
        check("load_we1", mem_write1, 0);
        check("load_a", r0_add_a, exp);
        check("load_b", r0_add_b, exp);
        check("idle_r1", r1_add_a, 0);
        check("idle_tw", add_tw, 0);
        @(negedge clk); load_valid = 1'b0;
    endtask

    initial begin
        int k, bad;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_we", {mem_write0, mem_write1}, 0);
        check("rst_bf_valid", bf_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", fft_done, 0);
        check("rst_bank", result_bank, 0);

        load_check(3, 1, 4);
        load_check(3, 6, 3);
        load_check(4, 1, 8);
        load_check(9, 3, 384);

        run_fft(3, 3, 0, 1);
        run_fft(4, 4, 1, 1);
        run_fft(1, 2, 0, 0);
        run_fft(15, 9, 0, 0);

        // abort in stage 1 of a full-size transform
        @(negedge clk); cfg_log2n = CW'(9); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!read_sel && k < 2000) begin @(negedge clk); k++; end
        check("reach_stage1", read_sel, 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_we", {mem_write0, mem_write1}, 0);
        check("abort_bf_valid", bf_valid, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (fft_done || mem_write0 || mem_write1 || busy) bad++;
            @(negedge clk);
        end
        check("abort_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
